alu_req_responder: RTL and testbench

- Handshaked, multi-cycle ALU responder: the serving end of the control-unit-to-ALU opcode/operand interface.
- The control unit raises a four-phase request carrying an opcode and two operands. This block computes the result and flags, then acknowledges and holds them until the request drops.
- Single-cycle ops take one execute cycle. MUL/DIV/MOD iterate bit-serially over WIDTH cycles.
- Sits between the control unit and the result/flag wires on the single system clock.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_muldiv.sv | 78 +++++++
 rtl/alu_req_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_req_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the handshaked ALU responder.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_MOD  = 4'd10;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_DEC  = 4'd12;
    localparam logic [3:0] OP_PASA = 4'd13;
    localparam logic [3:0] OP_PASB = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;
    localparam int F_E = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Bit-serial shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Outputs present the next iteration combinationally so the final step can be captured directly.
module alu_seq_muldiv #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [CW-1:0]        count
);

    logic                 busy_r;
    logic                 mode_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        count_r;

    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_shift_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   div_next_s;

    // One iteration of each algorithm; for divide, upper half is the partial remainder
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
        if (div_ge_s) begin
            div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    assign done      = busy_r && (count_r == CW'(WIDTH - 1));
    assign product   = mul_next_s;
    assign quotient  = div_next_s[WIDTH-1:0];
    assign remainder = div_next_s[2*WIDTH-1:WIDTH];
    assign count     = count_r;

    // Operand load on start, then one iteration per cycle until the last step is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            mode_r  <= 1'b0;
            opnd_r  <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
        end else if (start) begin
            busy_r  <= 1'b1;
            mode_r  <= mode;
            opnd_r  <= mode ? b : a;
            acc_r   <= {{WIDTH{1'b0}}, (mode ? a : b)};
            count_r <= {CW{1'b0}};
        end else if (busy_r) begin
            acc_r <= mode_r ? div_next_s : mul_next_s;
            if (done) begin
                busy_r  <= 1'b0;
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_req_responder.sv
// Serving end of the control-unit/ALU four-phase handshake: captures a request, executes it
// (single-cycle or bit-serial), then acknowledges with registered result and flags.
module alu_req_responder
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int FLAGS_W = 5
) (
    input  logic               clk,
    input  logic               iRst_n,
    input  logic               iReq,
    input  logic [3:0]         iOpCode,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    output logic               oAck,
    output logic               oBusy,
    output logic [WIDTH-1:0]   oResultado,
    output logic [FLAGS_W-1:0] oFlags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    state_t               state_r, state_next_s;
    logic [3:0]           op_r;
    logic [WIDTH-1:0]     a_r, b_r, res_r;
    logic [FLAGS_W-1:0]   flags_r;

    logic                 md_start_s, md_mode_s, md_done_s, md_last_s;
    logic [2*WIDTH-1:0]   md_product_s;
    logic [WIDTH-1:0]     md_quotient_s, md_remainder_s;
    logic [CW-1:0]        md_count_s;

    logic                 iter_s, div0_s;
    logic [WIDTH:0]       sum_s, diff_s, inc_s, dec_s;
    logic [WIDTH-1:0]     res_s, fv_s;
    logic                 c_s, v_s, e_s;
    logic [FLAGS_W-1:0]   flags_s;
    logic                 ack_s, busy_s;

    assign md_start_s = (state_r == S_IDLE) && iReq && op_is_iter(iOpCode)
                        && !((iOpCode != OP_MUL) && (iB == {WIDTH{1'b0}}));
    assign md_mode_s  = (iOpCode != OP_MUL);

    alu_seq_muldiv #(.WIDTH(WIDTH), .CW(CW)) u_muldiv (
        .clk       (clk),
        .rst_n     (iRst_n),
        .start     (md_start_s),
        .mode      (md_mode_s),
        .a         (iA),
        .b         (iB),
        .done      (md_done_s),
        .product   (md_product_s),
        .quotient  (md_quotient_s),
        .remainder (md_remainder_s),
        .count     (md_count_s)
    );

    assign iter_s    = op_is_iter(op_r);
    assign div0_s    = ((op_r == OP_DIV) || (op_r == OP_MOD)) && (b_r == {WIDTH{1'b0}});
    // Require the counter to agree with done so a stale done can never end EXEC early
    assign md_last_s = md_done_s && (md_count_s == CW'(WIDTH - 1));

    assign sum_s  = {1'b0, a_r} + {1'b0, b_r};
    assign diff_s = {1'b0, a_r} - {1'b0, b_r};
    assign inc_s  = {1'b0, a_r} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_s  = {1'b0, a_r} - {{WIDTH{1'b0}}, 1'b1};

    // Result and flag computation for the op being completed this cycle
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        e_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_s = sum_s[M:0];
                c_s   = sum_s[WIDTH];
                v_s   = (a_r[M] == b_r[M]) && (sum_s[M] != a_r[M]);
            end
            OP_SUB: begin
                res_s = diff_s[M:0];
                c_s   = diff_s[WIDTH];
                v_s   = (a_r[M] != b_r[M]) && (diff_s[M] != a_r[M]);
            end
            OP_CMP: begin
                res_s = {WIDTH{1'b0}};
                c_s   = diff_s[WIDTH];
                v_s   = (a_r[M] != b_r[M]) && (diff_s[M] != a_r[M]);
            end
            OP_AND:  res_s = a_r & b_r;
            OP_OR:   res_s = a_r | b_r;
            OP_XOR:  res_s = a_r ^ b_r;
            OP_NOT:  res_s = ~a_r;
            OP_SHL: begin
                res_s = {a_r[M-1:0], 1'b0};
                c_s   = a_r[M];
            end
            OP_SHR: begin
                res_s = {1'b0, a_r[M:1]};
                c_s   = a_r[0];
            end
            OP_MUL: begin
                res_s = md_product_s[M:0];
                c_s   = |md_product_s[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (div0_s) begin
                    res_s = {WIDTH{1'b1}};
                    e_s   = 1'b1;
                end else begin
                    res_s = md_quotient_s;
                end
            end
            OP_MOD: begin
                if (div0_s) begin
                    res_s = {WIDTH{1'b1}};
                    e_s   = 1'b1;
                end else begin
                    res_s = md_remainder_s;
                end
            end
            OP_INC: begin
                res_s = inc_s[M:0];
                c_s   = inc_s[WIDTH];
                v_s   = !a_r[M] && inc_s[M];
            end
            OP_DEC: begin
                res_s = dec_s[M:0];
                c_s   = dec_s[WIDTH];
                v_s   = a_r[M] && !dec_s[M];
            end
            OP_PASA: res_s = a_r;
            OP_PASB: res_s = b_r;
            default: res_s = {WIDTH{1'b0}};
        endcase
        if (op_r == OP_CMP) begin
            fv_s = diff_s[M:0];
        end else begin
            fv_s = res_s;
        end
        flags_s      = {FLAGS_W{1'b0}};
        flags_s[F_Z] = (fv_s == {WIDTH{1'b0}});
        flags_s[F_C] = c_s;
        flags_s[F_N] = fv_s[M];
        flags_s[F_V] = v_s;
        flags_s[F_E] = e_s;
    end

    // State register
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; iReq is ignored while executing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (iReq) begin
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (iter_s && !div0_s && !md_last_s) begin
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            S_DONE: begin
                if (iReq) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        case (state_r)
            S_EXEC: begin
                busy_s = 1'b1;
                ack_s  = 1'b0;
            end
            S_DONE: begin
                busy_s = 1'b0;
                ack_s  = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                ack_s  = 1'b0;
            end
        endcase
    end

    // Operand capture on acceptance, result/flags update only on entry to DONE
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            op_r    <= 4'd0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            flags_r <= {FLAGS_W{1'b0}};
        end else begin
            if ((state_r == S_IDLE) && iReq) begin
                op_r <= iOpCode;
                a_r  <= iA;
                b_r  <= iB;
            end
            if ((state_r == S_EXEC) && (state_next_s == S_DONE)) begin
                res_r   <= res_s;
                flags_r <= flags_s;
            end
        end
    end

    assign oAck       = ack_s;
    assign oBusy      = busy_s;
    assign oResultado = res_r;
    assign oFlags     = flags_r;

endmodule

// File: tb/tb_alu_req_responder.sv
// Randomized self-checking bench for alu_req_responder against an arithmetic reference model.
module tb_alu_req_responder;

    localparam int W  = 4;
    localparam int FW = 5;

    logic          clk = 1'b0;
    logic          iRst_n;
    logic          iReq;
    logic [3:0]    iOpCode;
    logic [W-1:0]  iA, iB;
    logic          oAck, oBusy;
    logic [W-1:0]  oResultado;
    logic [FW-1:0] oFlags;

    int n_checks = 0;
    int n_errors = 0;
    int prev_res = 0;
    int prev_flags = 0;

    alu_req_responder #(.WIDTH(W), .FLAGS_W(FW)) dut (
        .clk        (clk),
        .iRst_n     (iRst_n),
        .iReq       (iReq),
        .iOpCode    (iOpCode),
        .iA         (iA),
        .iB         (iB),
        .oAck       (oAck),
        .oBusy      (oBusy),
        .oResultado (oResultado),
        .oFlags     (oFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sgn(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference: result and {E,V,N,C,Z} from plain integer arithmetic
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int flags);
        int mask, smin, smax, r, fv, c, v, e, t;
        mask = (1 << W) - 1;
        smin = -(1 << (W - 1));
        smax = (1 << (W - 1)) - 1;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            0: begin t = a + b; r = t & mask; c = (t > mask); t = sgn(a) + sgn(b); v = (t < smin || t > smax); end
            1, 15: begin r = (a - b) & mask; c = (a < b); t = sgn(a) - sgn(b); v = (t < smin || t > smax); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (~a) & mask;
            6: begin r = (a * 2) & mask; c = (a > smax); end
            7: begin r = a / 2; c = a % 2; end
            8: begin t = a * b; r = t & mask; c = (t > mask); end
            9: begin if (b == 0) begin r = mask; e = 1; end else r = a / b; end
            10: begin if (b == 0) begin r = mask; e = 1; end else r = a % b; end
            11: begin r = (a + 1) & mask; c = (a == mask); v = (sgn(a) + 1 > smax); end
            12: begin r = (a - 1) & mask; c = (a == 0); v = (sgn(a) - 1 < smin); end
            13: r = a;
            14: r = b;
            default: r = 0;
        endcase
        fv = r;
        if (op == 15) begin
            r = 0;
        end
        flags = (e << 4) | (v << 3) | (((fv > smax) ? 1 : 0) << 2) | (c << 1) | ((fv == 0) ? 1 : 0);
        res = r;
    endfunction

    // One full four-phase transaction with latency, hold and release checks
    task automatic do_op(input int op, input int a, input int b, input int hold,
                         input bit early_drop, input bit mutate);
        int er, ef, lat_exp, n;
        model(op, a, b, er, ef);
        lat_exp = ((op == 8) || ((op == 9 || op == 10) && b != 0)) ? W : 1;
        iOpCode = 4'(op);
        iA = W'(a);
        iB = W'(b);
        iReq = 1'b1;
        tick();
        check("busy_exec", oBusy, 1);
        check("ack_exec", oAck, 0);
        check("res_held_exec", oResultado, prev_res);
        check("flags_held_exec", oFlags, prev_flags);
        if (mutate) begin
            iA = W'($urandom);
            iB = W'($urandom);
        end
        if (early_drop) begin
            iReq = 1'b0;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!oAck && n < 20);
        check("latency", n, lat_exp);
        check("result", oResultado, er);
        check("flags", oFlags, ef);
        check("busy_done", oBusy, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("ack_hold", oAck, 1);
            check("res_hold", oResultado, er);
            check("flags_hold", oFlags, ef);
        end
        iReq = 1'b0;
        tick();
        check("ack_release", oAck, 0);
        check("res_after_release", oResultado, er);
        prev_res = er;
        prev_flags = ef;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_ack;
        int op, a, b, hold;
        bit early, mut;
        iRst_n = 1'b0;
        iReq = 1'b0;
        iOpCode = 4'd0;
        iA = '0;
        iB = '0;
        repeat (2) @(negedge clk);
        iRst_n = 1'b1;
        tick();
        tick();
        check("rst_ack", oAck, 0);
        check("rst_busy", oBusy, 0);
        check("rst_res", oResultado, 0);
        check("rst_flags", oFlags, 0);

        do_op(0, 9, 8, 0, 1'b0, 1'b0);
        check("add_9_8_const", {oFlags, oResultado}, {5'b01010, 4'h1});
        do_op(1, 3, 5, 0, 1'b0, 1'b0);
        check("sub_3_5_const", {oFlags, oResultado}, {5'b00110, 4'hE});
        do_op(8, 5, 3, 1, 1'b0, 1'b0);
        do_op(8, 7, 6, 0, 1'b0, 1'b1);
        check("mul_7_6_const", {oFlags, oResultado}, {5'b00110, 4'hA});
        do_op(9, 13, 4, 0, 1'b0, 1'b0);
        do_op(10, 13, 4, 0, 1'b0, 1'b1);
        do_op(9, 7, 0, 0, 1'b0, 1'b0);
        check("div0_const", {oFlags, oResultado}, {5'b10100, 4'hF});
        do_op(10, 5, 0, 2, 1'b0, 1'b0);
        do_op(0, 4, 4, 5, 1'b0, 1'b1);
        do_op(9, 9, 2, 0, 1'b1, 1'b0);
        do_op(15, 2, 9, 0, 1'b1, 1'b0);

        // Reset two cycles into a multiply must abort without an acknowledge
        iOpCode = 4'd8;
        iA = 4'd7;
        iB = 4'd6;
        iReq = 1'b1;
        tick();
        tick();
        tick();
        iRst_n = 1'b0;
        #1;
        check("midrst_busy", oBusy, 0);
        check("midrst_ack", oAck, 0);
        check("midrst_res", oResultado, 0);
        check("midrst_flags", oFlags, 0);
        iReq = 1'b0;
        tick();
        iRst_n = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_ack = saw_ack | oAck;
        end
        check("no_spurious_ack", saw_ack, 0);
        prev_res = 0;
        prev_flags = 0;

        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 15);
            a = $urandom_range(0, 15);
            b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15);
            early = ($urandom_range(0, 3) == 0);
            hold = early ? 0 : $urandom_range(0, 3);
            mut = 1'($urandom_range(0, 1));
            do_op(op, a, b, hold, early, mut);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
